// File: rtl/xor_cipher_cfg_sequencer.sv
// Serial configuration sequencer for the dual XOR stream cipher: shifts a captured word into the
// config chain MSB first, optionally verifies it (define XOR_CFG_READBACK_EN), then enables TX/RX.
module xor_cipher_cfg_sequencer #(
    parameter int CFG_LEN = 64,
    parameter int CNT_W   = $clog2(CFG_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [CFG_LEN-1:0] cfg_word,
    input  logic               cfg_o,
    output logic               cfg_en,
    output logic               cfg_i,
    output logic               tx_en,
    output logic               rx_en,
    output logic               busy,
    output logic               ready,
    output logic               err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_VERIFY = 3'd2,
        ST_RUN    = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_LEN - 1);

    state_t             state_r;
    state_t             state_s;
    logic [CFG_LEN-1:0] shadow_r;
    logic [CFG_LEN-1:0] shadow_s;
    logic [CFG_LEN-1:0] shadow_rot_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               mis_r;
    logic               mis_s;
    logic               shift_act_r;
    logic               run_r;
    logic               err_r;

`ifdef XOR_CFG_READBACK_EN
    logic               cmp_s;
    assign cmp_s = cfg_o ^ shadow_r[CFG_LEN-1];
`else
    // Readback disabled: the chain output is deliberately left without any load.
    logic               unused_cfg_o_s;
    assign unused_cfg_o_s = cfg_o;
`endif

    // Rotation keeps the shadow equal to the original word after each full pass.
    assign shadow_rot_s = {shadow_r[CFG_LEN-2:0], shadow_r[CFG_LEN-1]};

    // Next-state, shadow, counter and mismatch-flag logic.
    always_comb begin
        state_s  = state_r;
        shadow_s = shadow_r;
        cnt_s    = cnt_r;
        mis_s    = mis_r;
        if (stop) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_RUN, ST_ERROR: begin
                    if (start) begin
                        shadow_s = cfg_word;
                        cnt_s    = {CNT_W{1'b0}};
                        mis_s    = 1'b0;
                        state_s  = ST_SHIFT;
                    end else begin
                        state_s  = state_r;
                    end
                end
                ST_SHIFT: begin
                    shadow_s = shadow_rot_s;
                    cnt_s    = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        cnt_s   = {CNT_W{1'b0}};
`ifdef XOR_CFG_READBACK_EN
                        state_s = ST_VERIFY;
`else
                        state_s = ST_RUN;
`endif
                    end else begin
                        state_s = ST_SHIFT;
                    end
                end
`ifdef XOR_CFG_READBACK_EN
                ST_VERIFY: begin
                    shadow_s = shadow_rot_s;
                    cnt_s    = cnt_r + CNT_W'(1);
                    mis_s    = mis_r | cmp_s;
                    if (cnt_r == CNT_LAST) begin
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = (mis_r | cmp_s) ? ST_ERROR : ST_RUN;
                    end else begin
                        state_s = ST_VERIFY;
                    end
                end
`endif
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shadow_r    <= {CFG_LEN{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            mis_r       <= 1'b0;
            shift_act_r <= 1'b0;
            run_r       <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            shadow_r    <= shadow_s;
            cnt_r       <= cnt_s;
            mis_r       <= mis_s;
            shift_act_r <= (state_s == ST_SHIFT) || (state_s == ST_VERIFY);
            run_r       <= (state_s == ST_RUN);
`ifdef XOR_CFG_READBACK_EN
            err_r       <= (state_s == ST_ERROR);
`else
            err_r       <= 1'b0;
`endif
        end
    end

    assign cfg_en = shift_act_r;
    assign busy   = shift_act_r;
    assign cfg_i  = shadow_r[CFG_LEN-1];
    assign tx_en  = run_r;
    assign rx_en  = run_r;
    assign ready  = run_r;
    assign err    = err_r;

endmodule

// File: tb/tb_xor_cipher_cfg_sequencer.sv
// Bench for xor_cipher_cfg_sequencer: timeline model of a load sequence plus a behavioural chain,
// checked every cycle, with hand-computed directed expectations. Follows XOR_CFG_READBACK_EN.
module tb_xor_cipher_cfg_sequencer;

    localparam int L = 8;
`ifdef XOR_CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam int TOTAL = RB ? 2 * L : L;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [L-1:0] cfg_word = 8'h00;
    logic         cfg_o;
    logic         cfg_en, cfg_i, tx_en, rx_en, busy, ready, err;

    int n_tests = 0;
    int n_fail  = 0;

    xor_cipher_cfg_sequencer #(.CFG_LEN(L)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_word(cfg_word),
        .cfg_o(cfg_o), .cfg_en(cfg_en), .cfg_i(cfg_i), .tx_en(tx_en), .rx_en(rx_en),
        .busy(busy), .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_t is the cycle number since the accepted start edge (0 = idle, TOTAL+1 = finished).
    int           m_t = 0;
    logic [L-1:0] m_word = 8'h00;
    bit           m_mis = 1'b0;
    bit           m_ci_known = 1'b1;
    int           flip_at = 0;

    function automatic logic exp_bit(input int t);
        return m_word[L - 1 - ((t - 1) % L)];
    endfunction

    // Behavioural config chain, with an optional injected readback error.
    logic [L-1:0] chain = 8'h00;
    always @(posedge clk) if (cfg_en) chain <= {chain[L-2:0], cfg_i};
    assign cfg_o = chain[L-1] ^ (flip_at != 0 && m_t == flip_at);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t <= 0; m_mis <= 1'b0; m_word <= 8'h00; m_ci_known <= 1'b1;
        end else if (stop) begin
            m_t <= 0; m_ci_known <= 1'b0;
        end else if (start && (m_t == 0 || m_t == TOTAL + 1)) begin
            m_t <= 1; m_word <= cfg_word; m_mis <= 1'b0; m_ci_known <= 1'b1;
        end else if (m_t >= 1 && m_t <= TOTAL) begin
            m_t <= m_t + 1;
            if (RB && m_t > L && cfg_o !== exp_bit(m_t)) m_mis <= 1'b1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("m_cfg_en", cfg_en, (m_t >= 1 && m_t <= TOTAL));
        check("m_busy",   busy,   (m_t >= 1 && m_t <= TOTAL));
        check("m_ready",  ready,  (m_t == TOTAL + 1 && !m_mis));
        check("m_tx_en",  tx_en,  (m_t == TOTAL + 1 && !m_mis));
        check("m_rx_en",  rx_en,  (m_t == TOTAL + 1 && !m_mis));
        check("m_err",    err,    (RB && m_t == TOTAL + 1 && m_mis));
        if (m_ci_known)
            check("m_cfg_i", cfg_i, (m_t >= 1 && m_t <= TOTAL) ? exp_bit(m_t) : m_word[L-1]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [L-1:0] w);
        cfg_word = w;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cfg_word = ~w;
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_cfg_en"}, cfg_en, 1'b0);
        check({name, "_cfg_i"},  cfg_i,  1'b0);
        check({name, "_busy"},   busy,   1'b0);
        check({name, "_ready"},  ready,  1'b0);
        check({name, "_tx_en"},  tx_en,  1'b0);
        check({name, "_rx_en"},  rx_en,  1'b0);
        check({name, "_err"},    err,    1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    initial begin
        logic [L-1:0] seq;
        seq = 8'h00;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Load 8'hA5: pattern 1,0,1,0,0,1,0,1 on each pass, then RUN.
        pulse_start(8'hA5);
        for (int c = 1; c <= TOTAL; c++) begin
            seq[L - 1 - ((c - 1) % L)] = cfg_i;
            check("t1_cfg_en", cfg_en, 1'b1);
            if (c == L)     check("t1_seq_shift", seq, 8'b1010_0101);
            if (c == 2 * L) check("t1_seq_verify", seq, 8'b1010_0101);
            tick();
        end
        check("t1_ready", ready, 1'b1);
        check("t1_tx_en", tx_en, 1'b1);
        check("t1_rx_en", rx_en, 1'b1);
        check("t1_err", err, 1'b0);
        check("t1_cfg_en_off", cfg_en, 1'b0);

        // Corrupted readback in VERIFY cycle 3 (or mid-SHIFT without readback).
        flip_at = RB ? L + 3 : 3;
        pulse_start(8'hA5);
        repeat (TOTAL) tick();
        flip_at = 0;
`ifdef XOR_CFG_READBACK_EN
        check("t2_err", err, 1'b1);
        check("t2_tx_en", tx_en, 1'b0);
        check("t2_rx_en", rx_en, 1'b0);
        check("t2_ready", ready, 1'b0);
`else
        check("t2_err_tied", err, 1'b0);
        check("t2_ready", ready, 1'b1);
`endif
        pulse_start(8'h3C);
        check("t2_err_cleared", err, 1'b0);
        repeat (TOTAL) tick();
        check("t2_reload_ready", ready, 1'b1);
        check("t2_reload_err", err, 1'b0);

        // Stop at SHIFT cycle 5, with an ignored start at cycle 3.
        pulse_start(8'hA5);
        tick();
        tick();
        cfg_word = 8'hFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_busy_start_ignored", busy, 1'b1);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t3_stop_cfg_en", cfg_en, 1'b0);
        check("t3_stop_busy", busy, 1'b0);
        check("t3_stop_err", err, 1'b0);
        check("t3_stop_ready", ready, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("t3_both_busy", busy, 1'b0);
        check("t3_both_cfg_en", cfg_en, 1'b0);
        tick();
        check("t3_idle_ready", ready, 1'b0);

        // Reload from RUN: 8'hA5 then 8'h0F.
        pulse_start(8'hA5);
        repeat (TOTAL) tick();
        check("t4_run", ready, 1'b1);
        pulse_start(8'h0F);
        check("t4_tx_drop", tx_en, 1'b0);
        check("t4_rx_drop", rx_en, 1'b0);
        for (int c = 1; c <= L; c++) begin
            seq[L - c] = cfg_i;
            tick();
        end
        check("t4_seq", seq, 8'b0000_1111);
        repeat (TOTAL - L) tick();
        check("t4_rerun_ready", ready, 1'b1);
        check("t4_rerun_tx", tx_en, 1'b1);

        // Asynchronous reset at cycle 10, between edges.
        pulse_start(8'hA5);
        repeat (9) tick();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("t5_async");
        @(negedge clk);
        #1;
        rst = 1'b0;
        tick();
        pulse_start(8'h3C);
        check("t5_restart_busy", busy, 1'b1);
        repeat (TOTAL) tick();
        check("t5_restart_ready", ready, 1'b1);
        check("t5_restart_err", err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
